// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: register-result scoreboard with Tuse/Tnew stall
// detection, multiply/divide busy tracking and EPC-write/eret interlock.
// Optional feature macro: HAZARD_MD_EN enables the multiply/divide busy
// counter (md_cnt). Without it, md_busy and stall_md are tied to 0.
module hazard_scoreboard #(
  parameter int TNEW_MAX    = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       d_issue,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_access,
  input  logic       d_epc_write,
  input  logic       d_eret,
  output logic       stall,
  output logic       stall_rs,
  output logic       stall_rt,
  output logic       stall_md,
  output logic       stall_eret,
  output logic       md_busy
);

  localparam int CW = (TNEW_MAX < 1) ? 1 : $clog2(TNEW_MAX + 1);

  logic [CW-1:0] r_sb [32];
  logic [1:0]    r_epc_pend;
  logic          w_accept;
  logic [CW-1:0] w_ent_rs;
  logic [CW-1:0] w_ent_rt;

  // Clamp the incoming Tnew to the largest latency the counters can hold.
  function automatic logic [CW-1:0] clamp_tnew(input logic [1:0] t);
    if (int'(t) > TNEW_MAX) clamp_tnew = CW'(TNEW_MAX);
    else                    clamp_tnew = CW'(t);
  endfunction

  // Count down by one, holding at zero.
  function automatic logic [CW-1:0] dec_sat(input logic [CW-1:0] v);
    dec_sat = (v == '0) ? v : v - CW'(1);
  endfunction

  // Register 0 is hardwired, so its entry always reads as ready.
  assign w_ent_rs = (d_rs == 5'd0) ? '0 : r_sb[d_rs];
  assign w_ent_rt = (d_rt == 5'd0) ? '0 : r_sb[d_rt];

  assign stall_rs   = (d_rs != 5'd0) && (32'(w_ent_rs) > 32'(d_tuse_rs));
  assign stall_rt   = (d_rt != 5'd0) && (32'(w_ent_rt) > 32'(d_tuse_rt));
  assign stall_eret = d_eret & (r_epc_pend != 2'b00);
  assign stall      = stall_rs | stall_rt | stall_md | stall_eret;

  // An issue is only taken when nothing stalls and no flush is squashing E.
  assign w_accept = d_issue & ~stall & ~flush;

  // Scoreboard: load the destination's Tnew on accept, age all others.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < 32; i++) r_sb[i] <= '0;
    end else begin
      r_sb[0] <= '0;
      for (int i = 1; i < 32; i++) begin
        if (w_accept && (d_dst == 5'(i))) r_sb[i] <= clamp_tnew(d_tnew);
        else                              r_sb[i] <= dec_sat(r_sb[i]);
      end
    end
  end

  // EPC writes in flight through E and M; eret must wait until both drain.
  always_ff @(posedge clk) begin
    if (reset || flush) r_epc_pend <= 2'b00;
    else                r_epc_pend <= {r_epc_pend[0], w_accept & d_epc_write};
  end

`ifdef HAZARD_MD_EN
  localparam int MDMAX = ((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1;
  localparam int MW    = $clog2(MDMAX + 1);

  logic [MW-1:0] r_md_cnt;

  // Multiply/divide busy counter; flush does not stop a started operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (w_accept && d_md_start) begin
      r_md_cnt <= d_md_div ? MW'(DIV_CYCLES + 1) : MW'(MULT_CYCLES + 1);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - MW'(1);
    end
  end

  assign md_busy  = (r_md_cnt != '0);
  assign stall_md = d_md_access & md_busy;
`else
  logic        w_unused_md;
  logic [31:0] w_unused_md_cfg;

  assign w_unused_md     = d_md_start ^ d_md_div ^ d_md_access;
  assign w_unused_md_cfg = 32'(MULT_CYCLES + DIV_CYCLES);
  assign md_busy         = 1'b0;
  assign stall_md        = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed hazard scenarios followed by
// randomized traffic checked against a ready-time reference model.
module tb_hazard_scoreboard;

  localparam int TNEW_MAX    = 2;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
`ifdef HAZARD_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, flush, d_issue;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_access, d_epc_write, d_eret;
  logic       stall, stall_rs, stall_rt, stall_md, stall_eret, md_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: absolute cycle at which each result / unit is ready.
  int cyc = 0;
  int ready [32];
  int md_done = 0;
  int epc_q [$];

  hazard_scoreboard #(
    .TNEW_MAX(TNEW_MAX), .MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .d_issue(d_issue),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .d_md_access(d_md_access), .d_epc_write(d_epc_write), .d_eret(d_eret),
    .stall(stall), .stall_rs(stall_rs), .stall_rt(stall_rt), .stall_md(stall_md),
    .stall_eret(stall_eret), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic int rem(input logic [4:0] r);
    if (r == 5'd0) return 0;
    return (ready[r] > cyc) ? ready[r] - cyc : 0;
  endfunction

  function automatic bit m_pend();
    foreach (epc_q[k]) if ((cyc - epc_q[k]) == 0 || (cyc - epc_q[k]) == 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_srs();
    return (d_rs != 5'd0) && (rem(d_rs) > int'(d_tuse_rs));
  endfunction
  function automatic bit m_srt();
    return (d_rt != 5'd0) && (rem(d_rt) > int'(d_tuse_rt));
  endfunction
  function automatic bit m_busy();
    return MD_EN && (md_done > cyc);
  endfunction
  function automatic bit m_smd();
    return d_md_access && m_busy();
  endfunction
  function automatic bit m_ser();
    return d_eret && m_pend();
  endfunction
  function automatic bit m_stall();
    return m_srs() || m_srt() || m_smd() || m_ser();
  endfunction

  task automatic model_edge();
    bit acc;
    acc = d_issue && !m_stall() && !flush;
    if (reset) begin
      foreach (ready[r]) ready[r] = 0;
      md_done = 0;
      epc_q.delete();
    end else if (flush) begin
      foreach (ready[r]) ready[r] = 0;
      epc_q.delete();
    end else if (acc) begin
      if (d_dst != 5'd0)
        ready[d_dst] = cyc + 1 + ((int'(d_tnew) > TNEW_MAX) ? TNEW_MAX : int'(d_tnew));
      if (d_md_start) md_done = cyc + 2 + (d_md_div ? DIV_CYCLES : MULT_CYCLES);
      if (d_epc_write) epc_q.push_back(cyc + 1);
    end
    cyc++;
    while (epc_q.size() > 0 && (cyc - epc_q[0]) > 1) void'(epc_q.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".stall"},      stall,      m_stall());
    chk({tag, ".stall_rs"},   stall_rs,   m_srs());
    chk({tag, ".stall_rt"},   stall_rt,   m_srt());
    chk({tag, ".stall_md"},   stall_md,   m_smd());
    chk({tag, ".stall_eret"}, stall_eret, m_ser());
    chk({tag, ".md_busy"},    md_busy,    m_busy());
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0; d_issue = 1'b0;
    d_rs = 5'd0; d_rt = 5'd0; d_dst = 5'd0;
    d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_tnew = 2'd0;
    d_md_start = 1'b0; d_md_div = 1'b0; d_md_access = 1'b0;
    d_epc_write = 1'b0; d_eret = 1'b0;
  endtask

  initial begin
    foreach (ready[r]) ready[r] = 0;
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset.stall", stall, 1'b0);
    chk("reset.md_busy", md_busy, 1'b0);
    chk_all("reset");

    // Load-use: lw r8 (tnew 2) then add reading r8 at tuse 1
    d_issue = 1'b1; d_dst = 5'd8; d_tnew = 2'd2;
    tick();
    d_dst = 5'd10; d_tnew = 2'd1; d_rs = 5'd8; d_tuse_rs = 2'd1;
    #1; chk("loaduse.c1", stall, 1'b1); chk_all("loaduse.c1");
    tick();
    #1; chk("loaduse.c2", stall, 1'b0); chk_all("loaduse.c2");
    tick();

    // Branch after ALU op: addu r9 (tnew 1) then beq reading r9 at tuse 0
    idle(); d_issue = 1'b1; d_dst = 5'd9; d_tnew = 2'd1;
    tick();
    idle(); d_issue = 1'b1; d_rt = 5'd9; d_tuse_rt = 2'd0;
    #1; chk("branch.c1", stall_rt, 1'b1); chk_all("branch.c1");
    tick();
    #1; chk("branch.c2", stall_rt, 1'b0); chk_all("branch.c2");
    tick();

    // Zero destination and overwrite of a pending load result
    idle(); d_issue = 1'b1; d_dst = 5'd0; d_tnew = 2'd2;
    tick();
    idle(); d_issue = 1'b1; d_rs = 5'd0; d_tuse_rs = 2'd0;
    #1; chk("zero.nostall", stall, 1'b0); chk_all("zero");
    idle(); d_issue = 1'b1; d_dst = 5'd5; d_tnew = 2'd2;
    tick();
    d_tnew = 2'd1;
    tick();
    idle(); d_issue = 1'b1; d_rs = 5'd5; d_tuse_rs = 2'd0;
    #1; chk("overwrite.c1", stall, 1'b1); chk_all("overwrite.c1");
    tick();
    #1; chk("overwrite.c2", stall, 1'b0); chk_all("overwrite.c2");
    tick();

`ifdef HAZARD_MD_EN
    // Divide busy: mfhi waits 11 cycles behind a div
    idle(); d_issue = 1'b1; d_md_start = 1'b1; d_md_div = 1'b1;
    tick();
    idle(); d_issue = 1'b1; d_md_access = 1'b1;
    for (int k = 0; k < 11; k++) begin
      #1; chk("div.busy_stall", stall_md, 1'b1); chk("div.busy", md_busy, 1'b1);
      tick();
    end
    #1; chk("div.done_stall", stall_md, 1'b0); chk("div.done_busy", md_busy, 1'b0);
    tick();
`endif

    // Eret behind mtc0 EPC: two-cycle interlock
    idle(); d_issue = 1'b1; d_epc_write = 1'b1;
    tick();
    idle(); d_issue = 1'b1; d_eret = 1'b1;
    #1; chk("eret.c1", stall_eret, 1'b1); chk_all("eret.c1");
    tick();
    #1; chk("eret.c2", stall_eret, 1'b1); chk_all("eret.c2");
    tick();
    #1; chk("eret.c3", stall_eret, 1'b0); chk_all("eret.c3");
    tick();
    // Flush during the first interlock cycle clears the pending EPC write
    idle(); d_issue = 1'b1; d_epc_write = 1'b1;
    tick();
    idle(); d_issue = 1'b1; d_eret = 1'b1; flush = 1'b1;
    #1; chk("eretfl.c1", stall_eret, 1'b1); chk_all("eretfl.c1");
    tick();
    flush = 1'b0;
    #1; chk("eretfl.c2", stall_eret, 1'b0); chk_all("eretfl.c2");
    tick();

    // Flush during a pending load while a divide is in progress
    idle(); d_issue = 1'b1; d_md_start = 1'b1; d_md_div = 1'b1;
    tick();
    idle(); d_issue = 1'b1; d_dst = 5'd8; d_tnew = 2'd2;
    tick();
    idle(); d_issue = 1'b1; d_rs = 5'd8; d_tuse_rs = 2'd0; d_md_access = 1'b1; flush = 1'b1;
    #1; chk("flush.rs_before", stall_rs, 1'b1); chk("flush.md_before", stall_md, MD_EN);
    chk_all("flush.c1");
    tick();
    flush = 1'b0;
    #1; chk("flush.rs_after", stall_rs, 1'b0); chk("flush.md_after", md_busy, MD_EN);
    chk("flush.stall_md", stall_md, MD_EN); chk_all("flush.c2");
    tick();

    // Randomized traffic against the reference model
    for (int k = 0; k < 3000; k++) begin
      reset       = ($urandom_range(0, 199) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      d_issue     = ($urandom_range(0, 3) != 0);
      d_rs        = 5'($urandom_range(0, 7));
      d_rt        = 5'($urandom_range(0, 7));
      d_dst       = 5'($urandom_range(0, 7));
      d_tuse_rs   = 2'($urandom_range(0, 3));
      d_tuse_rt   = 2'($urandom_range(0, 3));
      d_tnew      = 2'($urandom_range(0, 3));
      d_md_start  = ($urandom_range(0, 15) == 0);
      d_md_div    = 1'($urandom_range(0, 1));
      d_md_access = ($urandom_range(0, 3) == 0);
      d_epc_write = ($urandom_range(0, 7) == 0);
      d_eret      = ($urandom_range(0, 3) == 0);
      #1; chk_all("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter TNEW_MAX, default 2: largest result-latency value, in cycles after entering E, that the block tracks.
REQ-002 Parameter MULT_CYCLES, default 5: number of busy cycles of the multiply unit after the mult/madd E cycle.
REQ-003 Parameter DIV_CYCLES, default 10: number of busy cycles of the divide unit after the div E cycle.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  exception/eret flush of the E and M stages.
REQ-007 d_issue  input  1  instruction in D advances to E this cycle.
REQ-008 d_rs, d_rt  input  5 each  source register addresses of the D instruction.
REQ-009 d_tuse_rs, d_tuse_rt  input  2 each  Tuse values; 3 means the operand is not used.
REQ-010 d_dst  input  5  destination register of the D instruction; 0 means no write.
REQ-011 d_tnew  input  2  Tnew of the D instruction, measured at E entry.
REQ-012 d_md_start  input  1  D instruction starts multiply/divide.
REQ-013 d_md_div  input  1  with d_md_start: 1 = divide, 0 = multiply.
REQ-014 d_md_access  input  1  D instruction reads, writes or starts HI/LO.
REQ-015 d_epc_write  input  1  D instruction is mtc0 to register 14.
REQ-016 d_eret  input  1  D instruction is eret.
REQ-017 stall  output  1  OR of all stall causes.
REQ-018 stall_rs, stall_rt, stall_md, stall_eret  output  1 each  individual stall causes.
REQ-019 md_busy  output  1  md_cnt is nonzero.

Function
REQ-020 The block SHALL hold a 32-entry scoreboard; each entry is a down-counter of width clog2(TNEW_MAX+1).
REQ-021 Internal accept SHALL equal d_issue & ~stall & ~flush; d_issue while stalled or flushing SHALL be ignored.
REQ-022 On accept with d_dst!=0, entry[d_dst] SHALL load min(d_tnew, TNEW_MAX), overwriting any older value.
REQ-023 Every other nonzero entry SHALL decrement by 1 per cycle and SHALL saturate at 0.
REQ-024 Entry 0 SHALL always read as 0.
REQ-025 stall_rs SHALL equal (d_rs!=0) & (entry[d_rs] > d_tuse_rs); stall_rt is the same using d_rt and d_tuse_rt.
REQ-026 All stall outputs SHALL be combinational from registered state and the current D inputs, with no dependence on d_issue.
REQ-027 On accept with d_md_start, md_cnt SHALL load MULT_CYCLES+1, or DIV_CYCLES+1 when d_md_div is 1.
REQ-028 Otherwise md_cnt SHALL decrement toward 0.
REQ-029 stall_md SHALL equal d_md_access & (md_cnt!=0).
REQ-030 A 2-bit shift register epc_pend SHALL track in-flight EPC writes: bit0 takes accept & d_epc_write, and bit1 takes the old bit0.
REQ-031 stall_eret SHALL equal d_eret & (epc_pend!=0).
REQ-032 On flush, all scoreboard entries and epc_pend SHALL clear on the next edge.
REQ-033 md_cnt SHALL be unaffected by flush because an operation already started runs to completion.
REQ-034 When flush and d_issue occur in the same cycle, flush SHALL win and no entry SHALL be loaded.

Reset
REQ-035 With reset high at a rising edge, all scoreboard entries, md_cnt and epc_pend SHALL become 0.
REQ-036 After reset, all outputs SHALL be 0 whenever d_eret and d_md_access are 0.
REQ-037 Reset SHALL override flush and d_issue.

Configuration
REQ-038 With macro HAZARD_MD_EN defined, REQ-027 to REQ-029 and REQ-033 SHALL be implemented.
REQ-039 With HAZARD_MD_EN undefined, md_cnt SHALL NOT be implemented, and md_busy and stall_md SHALL be constant 0.

Verification
REQ-040 Load-use: accept lw with dst=8 and tnew=2, then present add with rs=8 and tuse_rs=1. Required: stall=1 for exactly 1 cycle, then 0.
REQ-041 Branch after ALU op: accept addu with dst=9 and tnew=1, then present beq with rt=9 and tuse_rt=0. Required: stall_rt=1 for 1 cycle.
REQ-042 Zero register and overwrite: an accept with dst=0 causes no stall. Accept lw with dst=5 and tnew=2, then addu with dst=5 and tnew=1; a reader with tuse=0 then stalls 1 cycle only.
REQ-043 Divide busy: accept div with default parameters, then present mfhi. Required: stall_md=1 for 11 cycles, with md_busy falling in the same cycle as stall_md.
REQ-044 Eret: accept mtc0 to EPC, then present eret. Required: stall_eret=1 for 2 cycles; a flush in the first of those cycles clears it on the next cycle.
REQ-045 Flush during a pending load: stall_rs drops the cycle after flush=1 and md_cnt keeps counting. Repeat with HAZARD_MD_EN undefined: stall_md stays 0 at all times.
